// File: rtl/cache_mem_ctrl.sv
// Line-transfer controller: serialises whole-line write-backs and refills into
// single-word request/grant bus beats. Optional watchdog: define MEM_TIMEOUT_EN.
module cache_mem_ctrl #(
  parameter int ADDR_W      = 64,
  parameter int WORD_W      = 64,
  parameter int LINE_WORDS  = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mem_rden,
  input  logic                         mem_wren,
  input  logic [ADDR_W-1:0]            mem_addr,
  input  logic [WORD_W*LINE_WORDS-1:0] mem_wdata,
  output logic [WORD_W*LINE_WORDS-1:0] mem_rdata,
  output logic                         mem_ready,
  output logic                         mem_err,
  output logic                         bus_req,
  output logic                         bus_we,
  output logic [ADDR_W-1:0]            bus_addr,
  output logic [WORD_W-1:0]            bus_wdata,
  input  logic                         bus_gnt,
  input  logic                         bus_rvalid,
  input  logic [WORD_W-1:0]            bus_rdata
);

  localparam int LINE_W = WORD_W * LINE_WORDS;
  localparam int BEAT_W = $clog2(LINE_WORDS);
  localparam int WB_SH  = $clog2(WORD_W / 8);

  if (LINE_WORDS < 2 || (LINE_WORDS & (LINE_WORDS - 1)) != 0 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("cache_mem_ctrl: LINE_WORDS must be a power of 2 >= 2 and TIMEOUT_CYC >= 1");
  end

  typedef enum logic [2:0] {IDLE, WR_BEAT, RD_REQ, RD_WAIT, DONE} state_t;

  state_t              r_state;
  logic [BEAT_W-1:0]   r_beat;
  logic [ADDR_W-1:0]   r_base;
  logic [LINE_W-1:0]   r_wline;
  logic [LINE_W-1:0]   r_rbuf;
  logic [LINE_W-1:0]   r_mem_rdata;
  logic                r_mem_ready;
  logic                r_mem_err;
  logic                r_bus_req;
  logic                r_bus_we;
  logic [ADDR_W-1:0]   r_bus_addr;
  logic [WORD_W-1:0]   r_bus_wdata;

  logic [BEAT_W-1:0]   w_beat_nxt;
  logic                w_last;
  logic [ADDR_W-1:0]   w_line_base;
  logic [ADDR_W-1:0]   w_nxt_addr;
  logic [LINE_W-1:0]   w_rline;
  logic                w_timeout;

  assign w_beat_nxt  = r_beat + 1'b1;
  assign w_last      = (r_beat == BEAT_W'(LINE_WORDS - 1));
  assign w_line_base = mem_addr & ~ADDR_W'(LINE_W / 8 - 1);
  assign w_nxt_addr  = r_base + (ADDR_W'(w_beat_nxt) << WB_SH);

  // NOTE: the copy-then-patch below is safe in always_comb only because the
  // full default assignment comes first, so no path leaves w_rline unassigned.
  always_comb begin
    w_rline = r_rbuf;
    w_rline[r_beat*WORD_W +: WORD_W] = bus_rdata;
  end

`ifdef MEM_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] r_wdog;
  logic            w_active;

  assign w_active  = (r_state == WR_BEAT) || (r_state == RD_REQ) || (r_state == RD_WAIT);
  assign w_timeout = w_active && !(bus_gnt || bus_rvalid) && (r_wdog == WD_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                               r_wdog <= '0;
    else if (!w_active || bus_gnt || bus_rvalid || w_timeout) r_wdog <= '0;
    else                                                    r_wdog <= r_wdog + 1'b1;
  end
`else
  assign w_timeout = 1'b0;
`endif

  // NOTE: the line latches sit behind the async reset too, so mem_rdata reads
  // as zero after reset instead of leaking a stale line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_beat      <= '0;
      r_base      <= '0;
      r_wline     <= '0;
      r_rbuf      <= '0;
      r_mem_rdata <= '0;
      r_mem_ready <= 1'b0;
      r_mem_err   <= 1'b0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
    end else begin
      // NOTE: non-blocking assignments here, so later overrides in this block
      // (the watchdog abort) win cleanly without ordering hazards.
      r_mem_ready <= 1'b0;
      r_mem_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (mem_wren || mem_rden) begin
            r_base     <= w_line_base;
            r_beat     <= '0;
            r_bus_req  <= 1'b1;
            r_bus_we   <= mem_wren;
            r_bus_addr <= w_line_base;
            if (mem_wren) begin
              r_wline     <= mem_wdata;
              r_bus_wdata <= mem_wdata[WORD_W-1:0];
              r_state     <= WR_BEAT;
            end else begin
              r_state <= RD_REQ;
            end
          end
        end
        WR_BEAT: begin
          if (bus_gnt) begin
            r_beat <= w_beat_nxt;
            if (w_last) begin
              r_bus_req   <= 1'b0;
              r_mem_ready <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_bus_addr  <= w_nxt_addr;
              r_bus_wdata <= r_wline[w_beat_nxt*WORD_W +: WORD_W];
            end
          end
        end
        RD_REQ: begin
          if (bus_gnt) begin
            r_bus_req <= 1'b0;
            r_state   <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (bus_rvalid) begin
            r_rbuf <= w_rline;
            r_beat <= w_beat_nxt;
            if (w_last) begin
              r_mem_rdata <= w_rline;
              r_mem_ready <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_bus_req  <= 1'b1;
              r_bus_addr <= w_nxt_addr;
              r_state    <= RD_REQ;
            end
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
      if (w_timeout) begin
        r_state     <= DONE;
        r_bus_req   <= 1'b0;
        r_mem_ready <= 1'b1;
        r_mem_err   <= 1'b1;
        if (!r_bus_we) r_mem_rdata <= '0;
      end
    end
  end

  assign mem_rdata = r_mem_rdata;
  assign mem_ready = r_mem_ready;
  assign mem_err   = r_mem_err;
  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Self-checking bench for cache_mem_ctrl: directed corner cases followed by
// randomised line transfers against a beat-level reference model.
module tb_cache_mem_ctrl;

  localparam int ADDR_W = 64;
  localparam int WORD_W = 64;
  localparam int LW     = 4;
  localparam int LINE_W = WORD_W * LW;
  localparam int LINE_B = LINE_W / 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              mem_rden, mem_wren;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata, mem_rdata;
  logic              mem_ready, mem_err;
  logic              bus_req, bus_we, bus_gnt, bus_rvalid;
  logic [ADDR_W-1:0] bus_addr;
  logic [WORD_W-1:0] bus_wdata, bus_rdata;

  int total = 0;
  int bad   = 0;
  logic [LINE_W-1:0] exp_rline;

  always #5 clk = ~clk;

  cache_mem_ctrl #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .LINE_WORDS(LW), .TIMEOUT_CYC(255)) dut (
    .clk(clk), .rst(rst), .mem_rden(mem_rden), .mem_wren(mem_wren), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_err(mem_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] l;
    for (int k = 0; k < LW; k++) l[k*WORD_W +: WORD_W] = {$urandom, $urandom};
    return l;
  endfunction

  // Drop requests and verify the controller stays quiet.
  task automatic idle(input int cycles);
    mem_wren = 1'b0; mem_rden = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      check("idle_ready", mem_ready, 1'b0);
      check("idle_req", bus_req, 1'b0);
    end
  endtask

  // One line transfer, called right after a negedge. The bus side answers with
  // random grant delays (or a forced stall on one beat) and a fixed read
  // latency; every beat is compared against base + 8*i and word i of the line.
  task automatic do_xfer(input bit wr, input bit rd, input logic [ADDR_W-1:0] addr,
                         input logic [LINE_W-1:0] wline, input int gmax, input int rvdly,
                         input int stall_beat, input int stall_len, input bit drop,
                         input int exp_cyc);
    logic [ADDR_W-1:0] base;
    logic [LINE_W-1:0] rline;
    int i, n, gdly, rv_cnt, nb;
    bit is_wr, waiting, started, done;
    base    = addr & ~ADDR_W'(LINE_B - 1);
    rline   = rand_line();
    is_wr   = wr;
    i = 0; n = 1; rv_cnt = 0;
    waiting = 0; started = 0; done = 0;
    gdly = (stall_beat == 0) ? stall_len : int'($urandom_range(0, gmax));
    mem_wren = wr; mem_rden = rd; mem_addr = addr; mem_wdata = wline;
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
      bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = {$urandom, $urandom};
      if (mem_ready) begin
        done = 1;
        check("beats_at_ready", i, LW);
        check("err_at_ready", mem_err, 1'b0);
        if (!is_wr) exp_rline = rline;
        check("rdata_at_ready", mem_rdata, exp_rline);
        if (exp_cyc > 0) check("latency", n, exp_cyc);
      end else begin
        if (is_wr && started && i < LW) check("wr_req_held", bus_req, 1'b1);
        if (bus_req && i < LW) begin
          started = 1;
          if (drop) begin mem_wren = 1'b0; mem_rden = 1'b0; end
          check("one_outstanding", waiting, 1'b0);
          check("bus_we", bus_we, is_wr);
          check("bus_addr", bus_addr, base + ADDR_W'(i * (WORD_W / 8)));
          if (is_wr) check("bus_wdata", bus_wdata, wline[i*WORD_W +: WORD_W]);
          else       bus_rvalid = 1'($urandom_range(0, 1));
          if (gdly > 0) gdly--;
          else begin
            bus_gnt = 1'b1;
            if (is_wr) begin i++; nb = i; end
            else begin waiting = 1; rv_cnt = rvdly; nb = i + 1; end
            gdly = (nb == stall_beat) ? stall_len : int'($urandom_range(0, gmax));
          end
        end else if (waiting) begin
          rv_cnt--;
          if (rv_cnt == 0) begin
            bus_rvalid = 1'b1;
            bus_rdata  = rline[i*WORD_W +: WORD_W];
            i++;
            waiting = 0;
          end
        end
        if (is_wr) bus_rvalid = 1'($urandom_range(0, 1));
      end
    end
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
    check("xfer_completes", done, 1'b1);
  endtask

  initial begin
    logic [LINE_W-1:0] l;
    bit w;
    rst = 1'b0; mem_rden = 1'b0; mem_wren = 1'b0; mem_addr = '0; mem_wdata = '0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    exp_rline = '0;
    #12;
    check("rst_req", bus_req, 1'b0);
    check("rst_ready", mem_ready, 1'b0);
    check("rst_rdata", mem_rdata, '0);
    check("rst_addr", bus_addr, '0);
    check("rst_we", bus_we, 1'b0);
    check("rst_wdata", bus_wdata, '0);
    check("rst_err", mem_err, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Write-back with immediate grants: base 0x1000_0020, ready in cycle 6.
    l = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
    do_xfer(1, 0, 64'h1000_0038, l, 0, 1, -1, 0, 0, LW + 2);
    idle(2);

    // Standalone refill, immediate rvalid: 2*LW+2.
    do_xfer(0, 1, 64'h3000_0040, '0, 0, 1, -1, 0, 0, 2 * LW + 2);
    idle(1);

    // Refill with rvalid two cycles after each grant.
    do_xfer(0, 1, 64'h2000_0000, '0, 0, 2, -1, 0, 0, 3 * LW + 2);
    idle(1);

    // Five-cycle grant stall on beat 2 of a write.
    do_xfer(1, 0, 64'h4000_0100, rand_line(), 0, 1, 2, 5, 0, LW + 2 + 5);
    idle(1);

    // Write-back, then refill requested in the mem_ready cycle.
    do_xfer(1, 0, 64'h5000_0060, rand_line(), 0, 1, -1, 0, 0, LW + 2);
    do_xfer(0, 1, 64'h6000_0020, '0, 0, 1, -1, 0, 0, 2 * LW + 3);
    idle(2);

    // Simultaneous requests: the write goes first.
    do_xfer(1, 1, 64'h7000_0008, rand_line(), 1, 1, -1, 0, 0, -1);
    idle(2);

    // Requests dropped mid-transfer still complete.
    do_xfer(0, 1, 64'h7100_0000, '0, 1, 1, -1, 0, 1, -1);
    idle(1);

    // Async reset during beat 1 of a refill.
    mem_rden = 1'b1; mem_addr = 64'h8000_0000; bus_gnt = 1'b1; bus_rvalid = 1'b1;
    bus_rdata = 64'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    check("pre_rst_req", bus_req, 1'b1);
    check("pre_rst_addr", bus_addr, 64'h8000_0008);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_req", bus_req, 1'b0);
    check("mid_rst_ready", mem_ready, 1'b0);
    check("mid_rst_rdata", mem_rdata, '0);
    check("mid_rst_addr", bus_addr, '0);
    mem_rden = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
    exp_rline = '0;
    @(negedge clk);
    rst = 1'b1;
    idle(6);

    // Randomised traffic with mixed gaps and back-to-back requests.
    for (int t = 0; t < 24; t++) begin
      w = 1'($urandom_range(0, 1));
      do_xfer(w, !w, {$urandom, $urandom}, rand_line(), 3, int'($urandom_range(1, 3)),
              -1, 0, 1'($urandom_range(0, 1)), -1);
      if ($urandom_range(0, 2) != 0) idle(int'($urandom_range(1, 3)));
    end
    idle(2);
    check("final_rdata", mem_rdata, exp_rline);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
